// File: rtl/dma_pkg.sv
// Shared types and cherry-float/fp16 casts for the UART burst DMA engine.
package dma_pkg;

  localparam int unsigned HDR_DIR_BIT   = 7;
  localparam int unsigned HDR_ADDR_HI_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WR_FETCH,
    ST_WR_MSB,
    ST_WR_LSB,
    ST_RD_MSB,
    ST_RD_LSB,
    ST_FIN
  } dma_state_e;

  typedef enum logic [1:0] {
    TX_LAUNCH,
    TX_GAP,
    TX_WAIT
  } tx_step_e;

  function automatic logic [15:0] cf_to_fp16(input logic [17:0] cf);
    return cf[17:2];
  endfunction

  function automatic logic [17:0] fp16_to_cf(input logic [15:0] h);
    return {h, 2'b00};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver; samples mid-bit and pulses uart_rx_valid for a byte with a good stop bit.
module uart_rx #(
  parameter int unsigned BIT_RATE = 9600,
  parameter int unsigned CLK_HZ   = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  output logic       uart_rx_valid,
  output logic [7:0] uart_rx_data
);

  localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q;
  logic [31:0] tick_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        rxd_s, tick_end;

  assign rxd_s    = sync_q[1];
  assign tick_end = (tick_q == CYCLES_PER_BIT - 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (!rxd_s) state_d = RX_START;
      RX_START: if (tick_q == HALF_BIT) state_d = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_end && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (tick_end) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q        <= '1;
      tick_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_data  <= '0;
    end else begin
      sync_q        <= {sync_q[0], uart_rxd};
      tick_q        <= (state_d != state_q || tick_end) ? '0 : tick_q + 32'd1;
      uart_rx_valid <= 1'b0;
      if (state_q == RX_START) bit_q <= '0;
      if (state_q == RX_DATA && tick_end) begin
        bit_q   <= bit_q + 3'd1;
        shift_q <= {rxd_s, shift_q[7:1]};
      end
      if (state_q == RX_STOP && tick_end && rxd_s) begin
        uart_rx_valid <= 1'b1;
        uart_rx_data  <= shift_q;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; busy from the cycle after uart_tx_en until the stop bit ends.
module uart_tx #(
  parameter int unsigned BIT_RATE = 9600,
  parameter int unsigned CLK_HZ   = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       uart_txd,
  output logic       uart_tx_busy,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data
);

  localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;

  logic [8:0]  frame_q;
  logic [3:0]  bit_q;
  logic [31:0] tick_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_txd     <= 1'b1;
      uart_tx_busy <= 1'b0;
      frame_q      <= '1;
      bit_q        <= '0;
      tick_q       <= '0;
    end else if (!uart_tx_busy) begin
      if (uart_tx_en) begin
        frame_q      <= {1'b1, uart_tx_data};
        uart_txd     <= 1'b0;
        uart_tx_busy <= 1'b1;
        bit_q        <= '0;
        tick_q       <= '0;
      end
    end else if (tick_q == CYCLES_PER_BIT - 1) begin
      tick_q <= '0;
      if (bit_q == 4'd9) begin
        uart_tx_busy <= 1'b0;
      end else begin
        bit_q    <= bit_q + 4'd1;
        uart_txd <= frame_q[0];
        frame_q  <= {1'b1, frame_q[8:1]};
      end
    end else begin
      tick_q <= tick_q + 32'd1;
    end
  end

endmodule

// File: rtl/dma_uart_burst.sv
// Bidirectional burst DMA over UART: header, then fp16 words out (write) or in (read),
// with a valid/ready write port and an inter-byte RX timeout.
module dma_uart_burst
  import dma_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BIT_RATE   = 9600,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned RX_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [17:0]       dma_dat_w,
  input  logic              dat_w_valid,
  output logic              dat_w_ready,
  output logic [17:0]       dma_dat_r,
  output logic              dat_r_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              uart_rxd,
  output logic              uart_txd
);

  dma_state_e      state_q, state_d;
  tx_step_e        step_q, step_d;
  logic [1:0]      hdr_idx_q, hdr_idx_d;
  logic [LEN_W:0]  cnt_q, cnt_d;
  logic            we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [15:0]     wfp_q;
  logic [7:0]      rx_msb_q;
  logic [31:0]     idle_q;
  logic            err_q, dat_r_valid_q;
  logic [17:0]     dma_dat_r_q;

  logic            uart_tx_en, uart_tx_busy;
  logic [7:0]      uart_tx_data;
  logic            uart_rx_valid;
  logic [7:0]      uart_rx_data;

  logic            accept_req, take_word, timeout, byte_sent, sending, rx_wait, last_word;
  logic [14:0]     addr15;
  logic [7:0]      hdr0;

  assign addr15    = 15'(addr_q);
  assign last_word = (cnt_q == {1'b0, len_q});
  assign sending   = (state_q == ST_HDR) || (state_q == ST_WR_MSB) || (state_q == ST_WR_LSB);
  assign rx_wait   = (state_q == ST_RD_MSB) || (state_q == ST_RD_LSB);
  assign byte_sent = (step_q == TX_WAIT) && !uart_tx_busy;
  assign timeout   = (RX_TIMEOUT != 0) && rx_wait && !uart_rx_valid
                     && (idle_q == RX_TIMEOUT);

  always_comb begin
    hdr0 = '0;
    hdr0[HDR_DIR_BIT] = we_q;
    hdr0[HDR_ADDR_HI_W-1:0] = addr15[14:8];
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    hdr_idx_d    = hdr_idx_q;
    cnt_d        = cnt_q;
    uart_tx_en   = 1'b0;
    uart_tx_data = '0;
    dat_w_ready  = 1'b0;
    accept_req   = 1'b0;
    take_word    = 1'b0;

    // Every byte send walks LAUNCH -> GAP -> WAIT; the GAP lets uart_tx_busy rise first.
    if (sending) begin
      uart_tx_en = (step_q == TX_LAUNCH);
      case (step_q)
        TX_LAUNCH: step_d = TX_GAP;
        TX_GAP:    step_d = TX_WAIT;
        default:   if (!uart_tx_busy) step_d = TX_LAUNCH;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          accept_req = 1'b1;
          state_d    = ST_HDR;
          step_d     = TX_LAUNCH;
          hdr_idx_d  = '0;
          cnt_d      = '0;
        end
      end
      ST_HDR: begin
        case (hdr_idx_q)
          2'd0:    uart_tx_data = hdr0;
          2'd1:    uart_tx_data = addr15[7:0];
          default: uart_tx_data = 8'(len_q);
        endcase
        if (byte_sent) begin
          if (hdr_idx_q == 2'd2) state_d = we_q ? ST_WR_FETCH : ST_RD_MSB;
          else                   hdr_idx_d = hdr_idx_q + 2'd1;
        end
      end
      ST_WR_FETCH: begin
        dat_w_ready = 1'b1;
        if (dat_w_valid) begin
          take_word = 1'b1;
          state_d   = ST_WR_MSB;
          step_d    = TX_LAUNCH;
        end
      end
      ST_WR_MSB: begin
        uart_tx_data = wfp_q[15:8];
        if (byte_sent) state_d = ST_WR_LSB;
      end
      ST_WR_LSB: begin
        uart_tx_data = wfp_q[7:0];
        if (byte_sent) begin
          if (last_word) begin
            state_d = ST_FIN;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_WR_FETCH;
          end
        end
      end
      ST_RD_MSB: begin
        if (timeout)            state_d = ST_IDLE;
        else if (uart_rx_valid) state_d = ST_RD_LSB;
      end
      ST_RD_LSB: begin
        if (timeout) begin
          state_d = ST_IDLE;
        end else if (uart_rx_valid) begin
          if (last_word) begin
            state_d = ST_FIN;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_RD_MSB;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      step_q    <= TX_LAUNCH;
      hdr_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      hdr_idx_q <= hdr_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q          <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      wfp_q         <= '0;
      rx_msb_q      <= '0;
      idle_q        <= '0;
      err_q         <= 1'b0;
      dat_r_valid_q <= 1'b0;
      dma_dat_r_q   <= '0;
    end else begin
      if (accept_req) begin
        we_q   <= we;
        addr_q <= addr;
        len_q  <= len;
      end
      if (take_word) wfp_q <= cf_to_fp16(dma_dat_w);
      if (state_q == ST_RD_MSB && uart_rx_valid) rx_msb_q <= uart_rx_data;
      // Idle counter sits at zero outside RD states, so entering RD_MSB starts it cleared.
      if (!rx_wait || uart_rx_valid) idle_q <= '0;
      else if (RX_TIMEOUT != 0)     idle_q <= idle_q + 32'd1;
      err_q         <= timeout;
      dat_r_valid_q <= 1'b0;
      if (state_q == ST_RD_LSB && uart_rx_valid) begin
        dma_dat_r_q   <= fp16_to_cf({rx_msb_q, uart_rx_data});
        dat_r_valid_q <= 1'b1;
      end
    end
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done        = (state_q == ST_FIN);
  assign err         = err_q;
  assign dat_r_valid = dat_r_valid_q;
  assign dma_dat_r   = dma_dat_r_q;

  uart_tx #(
    .BIT_RATE(BIT_RATE),
    .CLK_HZ  (CLK_HZ)
  ) u_uart_tx (
    .clk         (clk),
    .resetn      (resetn),
    .uart_txd    (uart_txd),
    .uart_tx_busy(uart_tx_busy),
    .uart_tx_en  (uart_tx_en),
    .uart_tx_data(uart_tx_data)
  );

  uart_rx #(
    .BIT_RATE(BIT_RATE),
    .CLK_HZ  (CLK_HZ)
  ) u_uart_rx (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rxd     (uart_rxd),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data (uart_rx_data)
  );

endmodule

// File: tb/tb_dma_uart_burst.sv
// Scoreboard bench for dma_uart_burst: stimulus queues expected TX bytes, read words and
// completion events; independent monitors decode the UART line and DUT pulses and compare.
module tb_dma_uart_burst;

  localparam int CPB    = 10;
  localparam int RX_TO  = 600;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 3;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [17:0]       dma_dat_w = '0;
  logic              dat_w_valid = 1'b0;
  logic              dat_w_ready;
  logic [17:0]       dma_dat_r;
  logic              dat_r_valid;
  logic              busy, done, err;
  logic              uart_rxd = 1'b1;
  logic              uart_txd;

  dma_uart_burst #(
    .CLK_HZ    (96000),
    .BIT_RATE  (9600),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .RX_TIMEOUT(RX_TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .len        (len),
    .dma_dat_w  (dma_dat_w),
    .dat_w_valid(dat_w_valid),
    .dat_w_ready(dat_w_ready),
    .dma_dat_r  (dma_dat_r),
    .dat_r_valid(dat_r_valid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .uart_rxd   (uart_rxd),
    .uart_txd   (uart_txd)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  int          tests = 0;
  int          fails = 0;
  int          evt_seen = 0;
  bit          mon_off = 1'b0;
  longint      err_cyc = 0;
  longint      stop_cyc = 0;
  int unsigned exp_tx[$];
  logic [17:0] exp_rd[$];
  int          exp_evt[$];   // 1 = done, 2 = err

  task automatic check(input string name, input longint act, input longint need);
    tests++;
    if (act != need) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, need);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // UART line decoder on uart_txd
  initial begin : tx_mon
    logic [7:0] b;
    logic       stopb;
    forever begin
      @(negedge clk);
      if (resetn && uart_txd === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        stopb = uart_txd;
        if (!mon_off) begin
          if (exp_tx.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got 0x%02h, required no byte", b);
          end else begin
            check("tx_byte", b, exp_tx.pop_front());
          end
          check("tx_stop", stopb, 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && dat_r_valid) begin
      if (exp_rd.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got 0x%05h, required no word", dma_dat_r);
      end else begin
        check("rd_data", dma_dat_r, exp_rd.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && (done || err)) begin
      check("done_err_exclusive", done && err, 0);
      check("busy_low_at_end", busy, 0);
      if (err) err_cyc = cyc;
      if (exp_evt.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL evt_unexpected: got done=%0b err=%0b, required none", done, err);
      end else begin
        check("evt_kind", done ? 1 : 2, exp_evt.pop_front());
      end
      evt_seen++;
    end
  end

  task automatic push_hdr(input bit w, input int unsigned a, input int unsigned l);
    exp_tx.push_back((w ? 128 : 0) + a / 256);
    exp_tx.push_back(a % 256);
    exp_tx.push_back(l);
  endtask

  task automatic start_req(input bit w, input int unsigned a, input int unsigned l);
    req  = 1'b1;
    we   = w;
    addr = ADDR_W'(a);
    len  = LEN_W'(l);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_evt(input int target, input int budget, input string name);
    int n = 0;
    while (evt_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, evt_seen >= target, 1);
    tick(2);
  endtask

  task automatic wait_hdr_sent(input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("hdr_sent_in_time", exp_tx.size(), 0);
  endtask

  task automatic give_word(input logic [17:0] w);
    int n = 0;
    dma_dat_w   = w;
    dat_w_valid = 1'b1;
    while (!dat_w_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("w_ready_seen", dat_w_ready, 1);
    @(negedge clk);
    dat_w_valid = 1'b0;
    check("w_ready_drop", dat_w_ready, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    stop_cyc = cyc;
    uart_rxd = 1'b1;
    tick(CPB);
  endtask

  task automatic do_write(input int unsigned a, input int unsigned l,
                          input logic [17:0] words[8], input int gap, input bit poke);
    int tgt;
    push_hdr(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      exp_tx.push_back(int'(words[i]) / 1024);
      exp_tx.push_back((int'(words[i]) / 4) % 256);
    end
    exp_evt.push_back(1);
    tgt = evt_seen + 1;
    start_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      tick(gap);
      give_word(words[i]);
      if (poke && i == 0) start_req(1'b0, $urandom_range(0, 4095), $urandom_range(0, 7));
    end
    wait_evt(tgt, 6000, "write_done_in_time");
  endtask

  task automatic do_read(input int unsigned a, input int unsigned l, input logic [15:0] h[8]);
    int tgt;
    push_hdr(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) exp_rd.push_back(18'(h[i]) * 18'd4);
    exp_evt.push_back(1);
    tgt = evt_seen + 1;
    start_req(1'b0, a, l);
    wait_hdr_sent(2000);
    tick(2 * CPB);
    for (int i = 0; i <= int'(l); i++) begin
      send_byte(h[i][15:8]);
      send_byte(h[i][7:0]);
    end
    wait_evt(tgt, 6000, "read_done_in_time");
  endtask

  logic [17:0] wv[8];
  logic [15:0] hv[8];
  int          tgt;
  longint      dly;

  initial begin
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_w_ready", dat_w_ready, 0);
    check("rst_r_valid", dat_r_valid, 0);
    check("rst_dat_r", dma_dat_r, 0);
    check("rst_txd", uart_txd, 1);
    tick(3);
    resetn = 1'b1;
    tick(5);

    // single-word write: bytes 80 05 00 3C 03
    wv[0] = 18'h0F00C;
    do_write(12'h005, 0, wv, 0, 1'b0);

    // RX traffic while idle must be dropped
    send_byte(8'h5A);
    tick(50);

    // two-word read
    hv[0] = 16'h3C00;
    hv[1] = 16'hC000;
    do_read(12'h012, 1, hv);

    // backpressure write
    for (int i = 0; i < 8; i++) wv[i] = 18'($urandom);
    do_write($urandom_range(0, 4095), 2, wv, 200, 1'b0);

    // wide address with a req poked mid-burst
    for (int i = 0; i < 8; i++) wv[i] = 18'($urandom);
    do_write(12'hABC, $urandom_range(0, 3), wv, 1, 1'b1);

    // maximum bursts
    for (int i = 0; i < 8; i++) wv[i] = 18'($urandom);
    do_write($urandom_range(0, 4095), 7, wv, 0, 1'b0);
    for (int i = 0; i < 8; i++) hv[i] = 16'($urandom);
    do_read($urandom_range(0, 4095), 7, hv);

    // RX timeout after a lone MSB
    push_hdr(1'b0, 12'h3A5, 1);
    exp_evt.push_back(2);
    tgt = evt_seen + 1;
    start_req(1'b0, 12'h3A5, 1);
    wait_hdr_sent(2000);
    tick(20);
    send_byte(8'h3C);
    wait_evt(tgt, RX_TO + 1000, "timeout_err_in_time");
    dly = err_cyc - stop_cyc;
    check("timeout_not_early", dly >= RX_TO, 1);
    check("timeout_not_late", dly <= RX_TO + 2 * CPB, 1);

    // randomized mix
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wv[i] = 18'($urandom);
        do_write($urandom_range(0, 4095), $urandom_range(0, 7), wv, $urandom_range(0, 5), 1'b0);
      end else begin
        for (int i = 0; i < 8; i++) hv[i] = 16'($urandom);
        do_read($urandom_range(0, 4095), $urandom_range(0, 7), hv);
      end
    end

    // reset during the first data MSB byte
    push_hdr(1'b1, 12'h1F0, 3);
    start_req(1'b1, 12'h1F0, 3);
    give_word(18'h2AAAA);
    mon_off = 1'b1;
    tick(3);
    check("busy_before_reset", busy, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_w_ready", dat_w_ready, 0);
    check("arst_r_valid", dat_r_valid, 0);
    check("arst_dat_r", dma_dat_r, 0);
    check("arst_txd", uart_txd, 1);
    tick(5);
    resetn = 1'b1;
    tick(150);
    exp_tx.delete();
    mon_off = 1'b0;
    wv[0] = 18'h3FFFF;
    wv[1] = 18'h00001;
    do_write(12'h7E1, 1, wv, 0, 1'b0);

    tick(50);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("evt_queue_empty", exp_evt.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
